subkey_word_gen: RTL and testbench
==================================

Name: subkey_word_gen

Overview:
- Downstream consumer of the 17-word extended-key word selector in the Skein-1024/Threefish key schedule.
- Given a subkey index s (0..20), streams the 16 Threefish-1024 subkey words, one per cycle, with valid/ready backpressure.
- Drives the selector's 5-bit select; adds the tweak words and s to words 13, 14 and 15.
- Output stream feeds the round datapath's key-injection adder.

Parameters:
- NUM_SUBKEYS, 21, number of legal subkey indices (0..NUM_SUBKEYS-1).
- WORD_W, 64, word width; fixed at 64, not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request to generate subkey subkey_idx_i.
- subkey_idx_i  in  5  subkey index s.
- key_i  in  1088  extended key (k0..k16), k_j = key_i[64j+63:64j]; caller holds it stable while busy_o is high.
- tweak_i  in  128  t0 = [63:0], t1 = [127:64]; latched at start.
- word_ready_i  in  1  consumer accepts word_o.
- busy_o  out  1  generation in progress.
- word_valid_o  out  1  word_o valid.
- word_o  out  64  subkey word.
- word_idx_o  out  4  index i of word_o (0..15).
- word_last_o  out  1  high with i=15.
- done_o  out  1  one-cycle pulse after the last handshake.
- err_o  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0.
- Reset mid-stream: aborts immediately. No done_o is issued.
- FSM IDLE:
  - start_i with s<=20: latch s, t0, t1, and t2 = t0^t1. Set sel = s mod 17 (s-17 if s>=17), i = 0. Go to LOAD. busy_o=1 from the next cycle.
  - start_i with s>20: err_o pulses the next cycle; stay IDLE.
- start_i is ignored whenever not IDLE.
- FSM LOAD, one cycle: register word i into the output register, then set word_valid_o=1. Go to STREAM.
  - First word is therefore valid 2 cycles after start.
- FSM STREAM:
  - Handshake = word_valid_o & word_ready_i.
  - On a handshake with i<15: load word i+1 in the same cycle. Valid stays high, giving back-to-back throughput of 1 word/cycle.
  - Without a handshake, word_o, word_idx_o and word_last_o hold stable.
  - On a handshake with i=15: valid drops; go to DONE.
- FSM DONE: done_o=1 and busy_o=0 for one cycle; go to IDLE. A start_i is accepted from the following IDLE cycle.
- Word i = k[(s+i) mod 17], plus an addition for the last three words:
  - i=13: + t[s mod 3].
  - i=14: + t[(s+1) mod 3].
  - i=15: + s, zero-extended to 64 bits.
- All additions are modulo 2^64 with carry-out discarded.
- sel is an incrementing counter that wraps 16 -> 0. No divider.
- s mod 3 and (s+1) mod 3 come from a small lookup on the latched s.
- Selector select = sel, combinational. The adder sits between the selector output and the output register.

Decomposition:
- Shared package skein_pkg:
  - WORD_W = 64, NUM_KEY_WORDS = 17, NUM_STATE_WORDS = 16, NUM_SUBKEYS = 21.
  - FSM state enum {IDLE, LOAD, STREAM, DONE}.
- Sub-module: one instance of the existing key_word_select, driven by sel and key_i.

Test Plan:
- Key pattern k_j = j; t0=0x10, t1=0x20 (t2=0x30). s=0, ready held 1 -> words 0..12 = 0..12, w13=0x1D, w14=0x2E, w15=0x0F. Valid on 16 consecutive cycles from cycle 2; last with i=15; done_o at the next cycle.
- Same key, s=5 -> w0=5, w11=0x10 (k16), w12=0 (wrap), w13=1+t2=0x31, w14=2+t0=0x12, w15=3+5=0x08.
- s=20 -> w0=k3=3, w13=k16+t2=0x40, w14=k0+t0=0x10, w15=k1+20=0x15.
- Backpressure: s=0, ready toggles 1,0,0,1 repeatedly -> word_o/idx stable while ready=0. Exactly 16 handshakes, no duplicates or skips. A start_i mid-stream is ignored.
- Arithmetic wrap: k15=0xFFFF_FFFF_FFFF_FFFF, s=17, i=15 selects k15 -> w15 = 0x0000_0000_0000_0010.
- s=21 -> err_o pulse, busy_o stays 0, no words. rst_i at word 7 of a stream -> all outputs 0 next cycle. A new start completes normally.

Source files
------------

// File: rtl/skein_pkg.sv
// Shared Skein-1024/Threefish key-schedule constants, FSM state type and mod-3 lookup.
// No logic of its own; imported by the subkey word generator and the word selector.
// No flow control; constants, types and a combinational helper only.
package skein_pkg;

    localparam int WORD_W          = 64;
    localparam int NUM_KEY_WORDS   = 17;
    localparam int NUM_STATE_WORDS = 16;
    localparam int NUM_SUBKEYS     = 21;
    localparam int SEL_W           = 5;
    localparam int IDX_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } gen_state_t;

    // Small table for subkey indices 0..20; avoids a divider on the latched index.
    function automatic logic [1:0] mod3(input logic [SEL_W-1:0] v);
        logic [1:0] r;
        r = 2'd2;
        case (v)
            5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18: r = 2'd0;
            5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16, 5'd19: r = 2'd1;
            default: r = 2'd2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_word_select.sv
// Picks one 64-bit word k[sel] out of the 17-word extended key.
// Latency: combinational. Backpressure: none; out-of-range selects return zero.
module key_word_select
    import skein_pkg::*;
(
    input  logic [NUM_KEY_WORDS*WORD_W-1:0] key_i,
    input  logic [SEL_W-1:0]                sel_i,
    output logic [WORD_W-1:0]               word_o
);

    always_comb begin
        word_o = '0;
        if (sel_i < SEL_W'(NUM_KEY_WORDS)) begin
            word_o = key_i[int'(sel_i)*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/subkey_word_gen.sv
// Streams the 16 Threefish-1024 subkey words for subkey index s, one word per handshake.
// Latency: first word valid 2 cycles after an accepted start, then 1 word/cycle.
// Backpressure: word_ready_i low holds word_o/word_idx_o/word_last_o stable.
module subkey_word_gen
    import skein_pkg::*;
#(
    parameter int NUM_SUBKEYS = 21,
    parameter int WORD_W      = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [4:0]                    subkey_idx_i,
    input  logic [NUM_KEY_WORDS*WORD_W-1:0] key_i,
    input  logic [2*WORD_W-1:0]           tweak_i,
    input  logic                          word_ready_i,
    output logic                          busy_o,
    output logic                          word_valid_o,
    output logic [WORD_W-1:0]             word_o,
    output logic [3:0]                    word_idx_o,
    output logic                          word_last_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam logic [SEL_W-1:0] MAX_S    = SEL_W'(NUM_SUBKEYS - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_KEY_WORDS - 1);

    gen_state_t state_q, state_d;

    logic [SEL_W-1:0]            s_q;
    logic [2:0][WORD_W-1:0]      t_q;
    logic [SEL_W-1:0]            sel_q;
    logic [IDX_W-1:0]            idx_q;
    logic [WORD_W-1:0]           word_q;
    logic [IDX_W-1:0]            word_idx_q;
    logic                        valid_q;
    logic                        last_q;
    logic                        err_q;

    logic                        start_ok;
    logic                        accept;
    logic                        hs;
    logic                        load_en;
    logic [1:0]                  s_mod3;
    logic [1:0]                  s1_mod3;
    logic [WORD_W-1:0]           sel_word;
    logic [WORD_W-1:0]           add_val;
    logic [WORD_W-1:0]           next_word;

    key_word_select u_sel (
        .key_i  (key_i),
        .sel_i  (sel_q),
        .word_o (sel_word)
    );

    assign start_ok = (subkey_idx_i <= MAX_S);
    assign accept   = (state_q == IDLE) && start_i && start_ok;
    assign hs       = valid_q && word_ready_i;
    assign load_en  = (state_q == LOAD) || ((state_q == STREAM) && hs && !last_q);

    assign s_mod3  = mod3(s_q);
    assign s1_mod3 = (s_mod3 == 2'd2) ? 2'd0 : s_mod3 + 2'd1;

    // Only the last three words of a subkey carry tweak / index injection.
    always_comb begin
        add_val = '0;
        case (idx_q)
            4'd13:   add_val = t_q[s_mod3];
            4'd14:   add_val = t_q[s1_mod3];
            4'd15:   add_val = {{(WORD_W-SEL_W){1'b0}}, s_q};
            default: add_val = '0;
        endcase
    end

    assign next_word = sel_word + add_val;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  if (hs && last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q        <= '0;
            t_q        <= '0;
            sel_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && start_i && !start_ok;
            if (accept) begin
                s_q    <= subkey_idx_i;
                t_q[0] <= tweak_i[WORD_W-1:0];
                t_q[1] <= tweak_i[2*WORD_W-1:WORD_W];
                t_q[2] <= tweak_i[WORD_W-1:0] ^ tweak_i[2*WORD_W-1:WORD_W];
                sel_q  <= (subkey_idx_i > LAST_SEL) ? subkey_idx_i - SEL_W'(NUM_KEY_WORDS)
                                                    : subkey_idx_i;
                idx_q  <= '0;
            end
            // sel/idx always point at the next word to be registered.
            if (load_en) begin
                word_q     <= next_word;
                word_idx_q <= idx_q;
                last_q     <= (idx_q == 4'd15);
                sel_q      <= (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                idx_q      <= idx_q + 1'b1;
            end
            if (load_en) begin
                valid_q <= 1'b1;
            end else if (hs && last_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busy_o       = (state_q == LOAD) || (state_q == STREAM);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;
    assign word_idx_o   = word_idx_q;
    assign word_last_o  = last_q;

endmodule

// File: tb/tb_subkey_word_gen.sv
// Randomized and directed bench for subkey_word_gen against a behavioural subkey model.
module tb_subkey_word_gen;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [4:0]    subkey_idx_i;
    logic [1087:0] key_i;
    logic [127:0]  tweak_i;
    logic          word_ready_i;
    logic          busy_o;
    logic          word_valid_o;
    logic [63:0]   word_o;
    logic [3:0]    word_idx_o;
    logic          word_last_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int failures = 0;

    logic          chk_en = 1'b0;
    int            cur_s = 0;
    int            exp_i = 0;
    logic [63:0]   got [16];

    subkey_word_gen dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .subkey_idx_i (subkey_idx_i),
        .key_i        (key_i),
        .tweak_i      (tweak_i),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .word_valid_o (word_valid_o),
        .word_o       (word_o),
        .word_idx_o   (word_idx_o),
        .word_last_o  (word_last_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [1087:0] key, input logic [127:0] tw,
                                               input int s, input int i);
        logic [63:0] t [3];
        logic [63:0] w;
        t[0] = tw[63:0];
        t[1] = tw[127:64];
        t[2] = t[0] ^ t[1];
        w = key[64*((s + i) % 17) +: 64];
        if (i == 13) w = w + t[s % 3];
        if (i == 14) w = w + t[(s + 1) % 3];
        if (i == 15) w = w + 64'(s);
        return w;
    endfunction

    // Every presented word must be the next expected one of the stream.
    always @(negedge clk_i) begin
        if (chk_en && !rst_i && word_valid_o) begin
            if (exp_i > 15) begin
                check("extra_word", 64'(word_idx_o), 64'hdead);
            end else begin
                check("word", word_o, model_word(key_i, tweak_i, cur_s, exp_i));
                check("word_idx", 64'(word_idx_o), 64'(exp_i));
                check("word_last", 64'(word_last_o), 64'(exp_i == 15));
                check("busy_in_stream", 64'(busy_o), 64'd1);
                if (word_ready_i) begin
                    got[exp_i] = word_o;
                    exp_i++;
                end
            end
        end
    end

    function automatic logic ready_pat(input int mode, input int c);
        logic r;
        r = 1'b1;
        if (mode == 1) r = (c % 4 == 0) || (c % 4 == 3);
        if (mode == 2) r = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic start_stream(input int s);
        for (int j = 0; j < 16; j++) got[j] = '0;
        cur_s = s;
        exp_i = 0;
        chk_en = 1'b1;
        word_ready_i = 1'b0;
        start_i = 1'b1;
        subkey_idx_i = 5'(s);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("valid_cycle1", 64'(word_valid_o), 64'd0);
        @(posedge clk_i); #1;
        check("valid_cycle2", 64'(word_valid_o), 64'd1);
    endtask

    task automatic run_stream(input int s, input int mode, input bit poke_start);
        int c;
        start_stream(s);
        for (c = 0; c < 400; c++) begin
            word_ready_i = ready_pat(mode, c);
            start_i = poke_start && (c == 5);
            subkey_idx_i = 5'd3;
            @(posedge clk_i); #1;
            if (exp_i == 16) break;
        end
        start_i = 1'b0;
        word_ready_i = 1'b0;
        check("handshakes", 64'(exp_i), 64'd16);
        if (mode == 0) check("throughput", 64'(c), 64'd15);
        check("done_pulse", 64'(done_o), 64'd1);
        check("busy_at_done", 64'(busy_o), 64'd0);
        check("valid_at_done", 64'(word_valid_o), 64'd0);
        @(posedge clk_i); #1;
        check("done_clear", 64'(done_o), 64'd0);
        chk_en = 1'b0;
    endtask

    task automatic pattern_key();
        for (int j = 0; j < 17; j++) key_i[64*j +: 64] = 64'(j);
        tweak_i = {64'h20, 64'h10};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(word_valid_o), 64'd0);
        check({tag, "_word"}, word_o, 64'd0);
        check({tag, "_idx"}, 64'(word_idx_o), 64'd0);
        check({tag, "_last"}, 64'(word_last_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        subkey_idx_i = '0;
        word_ready_i = 1'b0;
        pattern_key();
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_stream(0, 0, 1'b0);
        check("s0_w0", got[0], 64'h0);
        check("s0_w12", got[12], 64'hC);
        check("s0_w13", got[13], 64'h1D);
        check("s0_w14", got[14], 64'h2E);
        check("s0_w15", got[15], 64'h0F);

        run_stream(5, 0, 1'b0);
        check("s5_w0", got[0], 64'h5);
        check("s5_w11", got[11], 64'h10);
        check("s5_w12", got[12], 64'h0);
        check("s5_w13", got[13], 64'h31);
        check("s5_w14", got[14], 64'h12);
        check("s5_w15", got[15], 64'h08);

        run_stream(20, 0, 1'b0);
        check("s20_w0", got[0], 64'h3);
        check("s20_w13", got[13], 64'h40);
        check("s20_w14", got[14], 64'h10);
        check("s20_w15", got[15], 64'h15);

        run_stream(0, 1, 1'b1);
        check("bp_w13", got[13], 64'h1D);

        key_i[64*15 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_stream(17, 0, 1'b0);
        check("wrap_w15", got[15], 64'h10);
        check("wrap_w0", got[0], 64'h0);
        pattern_key();

        start_i = 1'b1;
        subkey_idx_i = 5'd21;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("err_pulse", 64'(err_o), 64'd1);
        check("err_busy", 64'(busy_o), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            check("err_no_valid", 64'(word_valid_o), 64'd0);
            check("err_clear", 64'(err_o), 64'd0);
        end

        start_stream(0);
        word_ready_i = 1'b1;
        for (int c = 0; c < 40 && exp_i < 7; c++) begin
            @(posedge clk_i); #1;
        end
        check("mid_idx7", 64'(word_idx_o), 64'd7);
        chk_en = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_all_zero("midreset");
        rst_i = 1'b0;
        word_ready_i = 1'b0;
        @(posedge clk_i); #1;
        check("midreset_no_done", 64'(done_o), 64'd0);
        run_stream(9, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 34; j++) key_i[32*j +: 32] = $urandom;
            for (int j = 0; j < 4; j++) tweak_i[32*j +: 32] = $urandom;
            run_stream(int'($urandom_range(0, 20)), 2, r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
